bitrev_reorder: RTL and testbench
=================================

Name: bitrev_reorder

Overview:
- Output reorder stage placed directly downstream of the last bf_stage in the radix-2 SDF pipeline.
- The SDF chain emits each 2^N-point frame in bit-reversed frequency order; this block double-buffers each frame and replays it in natural order 0..2^N-1.
- Data is fixed-point complex and passes through unmodified; only the order changes.

Parameters:
- N, 3, log2 of frame length; frame = 2^N samples, same meaning as N in bf_stage / gen_shuffle_idx.
- W, 16, signed width of each real/imag component.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample present this cycle.
- in_re  in  W  signed real part, bit-reversed frame order.
- in_im  in  W  signed imag part.
- out_valid  out  1  output sample present this cycle.
- out_re  out  W  signed real part, natural order.
- out_im  out  W  signed imag part.
- out_idx  out  N  natural-order frequency index of the current output.
- out_last  out  1  high with the sample where out_idx = 2^N-1.

Behaviour:
- Storage:
  - 2 banks × 2^N complex words, 2W bits each.
  - One write port and one synchronous-read port.
- Write side:
  - wr_cnt (N bits) and wr_bank (1 bit).
  - Each cycle with in_valid=1, write {in_re,in_im} to bank wr_bank at address bitrev(wr_cnt), then wr_cnt+1.
  - When wr_cnt wraps from 2^N-1 to 0, set full[wr_bank]=1 and toggle wr_bank on the same edge.
- Gaps: in_valid may drop at any time; wr_cnt holds. No frame-start signal exists; frame alignment comes only from reset.
- Read side FSM:
  - IDLE -> READ when full[rd_bank]=1; rd_addr=0.
  - READ: issue rd_addr, increment each cycle.
  - When rd_addr = 2^N-1 is issued: clear full[rd_bank], toggle rd_bank, then:
    - go to READ with rd_addr=0 if the other bank is full (no bubble between frames);
    - otherwise go to IDLE.
- Latency:
  - Last input of a frame accepted at edge k.
  - out_valid first high after edge k+2.
  - out_valid stays high for exactly 2^N consecutive cycles, with out_idx = 0,1,...,2^N-1.
- Output registers: out_valid, out_idx and out_last come from a 1-cycle delayed copy of FSM state and rd_addr, aligned with the RAM read data.
- Overflow cannot occur:
  - A bank drains in 2^N cycles; the writer needs ≥2^N cycles to fill the other bank.
  - Writing into a bank whose full flag is set is a design error; the bench asserts it never happens.
- Simultaneous clear and set: if the writer sets full[b] on the same edge the reader clears full[b'] with b≠b', both take effect.
- Reset (asynchronous, any time, including mid-frame):
  - Cleared: wr_cnt, rd_addr, wr_bank, rd_bank, full[1:0], FSM=IDLE.
  - Outputs: out_valid=0, out_last=0, out_idx=0, out_re=0, out_im=0.
  - RAM contents are not cleared.
  - A partial frame in flight is discarded; the first in_valid after reset is sample 0 of a new frame.
- When out_valid=0, out_re/out_im hold their last value; the bench does not check them.

Decomposition:
- Shared package fft_pkg:
  - bitrev function parameterised on N, also used by gen_shuffle_idx.
  - Reader state enum {IDLE, READ}.
- One sub-module, reorder_ram:
  - Simple dual-port, 2^(N+1) × 2W bits.
  - Address = {bank, addr}; write enable; registered read.

Test Plan:
- Single frame, N=3, W=16: in_re = 0,4,2,6,1,5,3,7 (in_im = -in_re) on 8 consecutive cycles -> 2 cycles after the last input, out_re = 0..7 and out_im = 0,-1..-7; out_idx = 0..7; out_last only at idx 7; out_valid high exactly 8 cycles.
- Back-to-back frames: 3 frames streamed with in_valid held high (frame f values = bitrev order of 8f..8f+7) -> 24 contiguous out_valid cycles, values 0..23 in order, no bubbles.
- Gapped input: same frame with in_valid toggling 1,0,1,0... -> output still 0..7, contiguous, starting 2 cycles after the 8th accepted sample.
- Reset mid-operation: assert rst after 5 inputs of frame 0, also while a prior frame is mid-readout -> out_valid falls immediately (asynchronously); the next 8 inputs form a clean frame, reordered correctly.
- Extremes: in_re/in_im = 0x7FFF and 0x8000 alternating in a frame -> values reproduced bit-exact at their natural-order positions.
- Random: 100 frames of random data with random in_valid density ≥50% -> scoreboard matches a bitrev reference model; full-bank write assertion never fires.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT pipeline definitions: output-reader state and the bit-reverse helper
// used for both the reorder buffer and shuffle-index generation.
package fft_pkg;

  localparam int BR_MAX_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_e;

  // Reverses the low n bits of v; bits at and above n are returned as zero.
  function automatic logic [BR_MAX_W-1:0] bitrev(input logic [BR_MAX_W-1:0] v,
                                                 input int n);
    logic [BR_MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < BR_MAX_W; i++) begin
      if (i < n) r[i] = v[n-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/bitrev_reorder_if.sv
// Sample stream bundle for the bit-reverse reorder stage: bit-reversed input side
// and natural-order output side.
interface bitrev_reorder_if #(
  parameter int N = 3,
  parameter int W = 16
);

  logic                in_valid;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic [N-1:0]        out_idx;
  logic                out_last;

  modport master (
    output in_valid, in_re, in_im,
    input  out_valid, out_re, out_im, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_re, in_im,
    output out_valid, out_re, out_im, out_idx, out_last
  );

endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port whose
// output holds when no read is issued.
module reorder_ram #(
  parameter int AW = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata_p1;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // read data register is cleared so the block's data outputs reset to zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_p1 <= '0;
    end else if (i_re) begin
      r_rdata_p1 <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/bitrev_reorder.sv
// Double-buffered reorder stage: captures each bit-reversed SDF output frame and
// replays it in natural frequency order.
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic            clk,
  input  logic            rst,
  bitrev_reorder_if.slave io
);

  localparam logic [N-1:0] LAST_ADDR = '1;

  logic [N-1:0] r_wr_cnt;
  logic         r_wr_bank;
  logic [1:0]   r_full;
  rd_state_e    r_state;
  logic [N-1:0] r_rd_addr;
  logic         r_rd_bank;
  logic         r_vld_p1;
  logic [N-1:0] r_idx_p1;
  logic         r_last_p1;

  logic           w_wr_wrap;
  logic           w_rd_wrap;
  logic           w_rd_en;
  logic [1:0]     w_set_full;
  logic [1:0]     w_clr_full;
  logic [N-1:0]   w_wr_addr_br;
  logic [N:0]     w_wr_addr;
  logic [N:0]     w_rd_addr;
  logic [2*W-1:0] w_wdata;
  logic [2*W-1:0] w_rdata;

  assign w_wr_wrap    = io.in_valid && (r_wr_cnt == LAST_ADDR);
  assign w_rd_wrap    = (r_state == READ) && (r_rd_addr == LAST_ADDR);
  assign w_rd_en      = (r_state == READ);
  assign w_set_full   = w_wr_wrap ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr_full   = w_rd_wrap ? (2'b01 << r_rd_bank) : 2'b00;
  assign w_wr_addr_br = N'(bitrev(BR_MAX_W'(r_wr_cnt), N));
  assign w_wr_addr    = {r_wr_bank, w_wr_addr_br};
  assign w_rd_addr    = {r_rd_bank, r_rd_addr};
  assign w_wdata      = {io.in_re, io.in_im};

  // Write side: scatter into the current bank at bit-reversed addresses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt  <= '0;
      r_wr_bank <= 1'b0;
    end else if (io.in_valid) begin
      r_wr_cnt <= r_wr_cnt + 1'b1;
      if (w_wr_wrap) r_wr_bank <= ~r_wr_bank;
    end
  end

  // Writer sets and reader clears always target different banks, so both apply
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_full <= 2'b00;
    end else begin
      r_full <= (r_full & ~w_clr_full) | w_set_full;
    end
  end

  // Read side: sequential replay, then the p1 stage aligned with RAM read data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rd_addr <= '0;
      r_rd_bank <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_idx_p1  <= '0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p1  <= (r_state == READ);
      r_idx_p1  <= r_rd_addr;
      r_last_p1 <= w_rd_wrap;
      case (r_state)
        IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_state   <= READ;
            r_rd_addr <= '0;
          end
        end
        READ: begin
          r_rd_addr <= r_rd_addr + 1'b1;
          if (w_rd_wrap) begin
            r_rd_bank <= ~r_rd_bank;
            r_state   <= r_full[~r_rd_bank] ? READ : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  reorder_ram #(
    .AW(N + 1),
    .DW(2 * W)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_we   (io.in_valid),
    .i_waddr(w_wr_addr),
    .i_wdata(w_wdata),
    .i_re   (w_rd_en),
    .i_raddr(w_rd_addr),
    .o_rdata(w_rdata)
  );

  assign io.out_valid = r_vld_p1;
  assign io.out_idx   = r_idx_p1;
  assign io.out_last  = r_last_p1;
  assign io.out_re    = w_rdata[2*W-1:W];
  assign io.out_im    = w_rdata[W-1:0];

endmodule

// File: tb/tb_bitrev_reorder.sv
// Scoreboard bench for bitrev_reorder: a frame-level reference model queues the
// natural-order samples and a negedge monitor compares every output beat.
module tb_bitrev_reorder;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int FL = 1 << N;

  logic clk = 1'b0;
  logic rst;

  bitrev_reorder_if #(.N(N), .W(W)) ifc ();

  bitrev_reorder #(.N(N), .W(W)) dut (
    .clk(clk),
    .rst(rst),
    .io (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    int                  idx;
  } exp_t;

  exp_t q[$];
  logic signed [W-1:0] fr_re[FL];
  logic signed [W-1:0] fr_im[FL];
  int fcnt = 0;
  int total = 0;
  int bad = 0;

  function automatic int tb_br(input int x);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (x[i]) r = r + (1 << (N - 1 - i));
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: gather a frame of accepted inputs; natural index j holds input position bitrev(j)
  always @(posedge clk) begin
    if (!rst && ifc.in_valid) begin
      total++;
      if (dut.r_full[dut.r_wr_bank] && !dut.w_clr_full[dut.r_wr_bank]) begin
        bad++;
        $display("FAIL full_bank_write: bank %0d written while full at %0t", dut.r_wr_bank, $time);
      end
      fr_re[fcnt] = ifc.in_re;
      fr_im[fcnt] = ifc.in_im;
      fcnt++;
      if (fcnt == FL) begin
        for (int j = 0; j < FL; j++) begin
          exp_t e;
          e.re  = fr_re[tb_br(j)];
          e.im  = fr_im[tb_br(j)];
          e.idx = j;
          q.push_back(e);
        end
        fcnt = 0;
      end
    end
  end

  always @(posedge rst) begin
    q.delete();
    fcnt = 0;
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst && ifc.out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_re", 32'(ifc.out_re), 32'(e.re));
        chk("out_im", 32'(ifc.out_im), 32'(e.im));
        chk("out_idx", 32'(ifc.out_idx), e.idx);
        chk("out_last", 32'(ifc.out_last), (e.idx == FL - 1) ? 1 : 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send1(input logic signed [W-1:0] re, input logic signed [W-1:0] im);
    ifc.in_valid = 1'b1;
    ifc.in_re    = re;
    ifc.in_im    = im;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int p = 0; p < FL; p++) begin
      send1(16'(base + tb_br(p)), 16'(-(base + tb_br(p))));
      if (gap && p < FL - 1) idle(1);
    end
  endtask

  // Called right after the last input edge: two quiet cycles, then len valid beats
  task automatic check_latency(input int len);
    @(negedge clk);
    chk("lat_vld_k0", 32'(ifc.out_valid), 0);
    @(negedge clk);
    chk("lat_vld_k1", 32'(ifc.out_valid), 0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      chk("burst_vld", 32'(ifc.out_valid), 1);
    end
    @(negedge clk);
    chk("burst_end", 32'(ifc.out_valid), 0);
  endtask

  task automatic wait_burst(input int len);
    int waited;
    int cnt;
    waited = 0;
    cnt = 0;
    @(negedge clk);
    while (!ifc.out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      chk("burst_timeout", 0, 1);
    end else begin
      while (ifc.out_valid && cnt < len + 10) begin
        cnt++;
        @(negedge clk);
      end
      chk("burst_len", cnt, len);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.in_re    = '0;
    ifc.in_im    = '0;
    idle(3);
    chk("rst_out_valid", 32'(ifc.out_valid), 0);
    chk("rst_out_last", 32'(ifc.out_last), 0);
    chk("rst_out_idx", 32'(ifc.out_idx), 0);
    chk("rst_out_re", 32'(ifc.out_re), 0);
    chk("rst_out_im", 32'(ifc.out_im), 0);
    rst = 1'b0;
    idle(2);

    // single frame
    send_frame(0, 1'b0);
    check_latency(FL);
    idle(5);

    // three frames back to back
    fork
      begin
        send_frame(0, 1'b0);
        send_frame(8, 1'b0);
        send_frame(16, 1'b0);
      end
      wait_burst(3 * FL);
    join
    idle(5);

    // gapped input
    send_frame(0, 1'b1);
    check_latency(FL);
    idle(5);

    // reset during readout of one frame and partway through the next
    send_frame(100, 1'b0);
    for (int p = 0; p < 5; p++) send1(16'(200 + p), 16'(-p));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(ifc.out_valid), 0);
    chk("async_rst_last", 32'(ifc.out_last), 0);
    chk("async_rst_idx", 32'(ifc.out_idx), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    send_frame(40, 1'b0);
    check_latency(FL);
    idle(5);

    // full-scale extremes
    for (int p = 0; p < FL; p++) begin
      if (p % 2 == 0) send1(16'sh7FFF, 16'sh8000);
      else            send1(16'sh8000, 16'sh7FFF);
    end
    check_latency(FL);
    idle(5);

    // random frames with random gaps
    for (int s = 0; s < 100 * FL; s++) begin
      while ($urandom_range(0, 2) == 0) idle(1);
      send1(16'($urandom), 16'($urandom));
    end
    idle(30);
    chk("queue_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
